// File: rtl/mant_mul_ctrl.sv
// mant_mul_ctrl: sequential shift-and-add mantissa multiplier controller.
// Accepts two MW-bit mantissas, performs one partial-product addition per
// cycle on an external 2*MW-bit adder, and returns the 2*MW-bit product.
// Optional build macro: MANT_MUL_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are all zero).
module mant_mul_ctrl #(
    parameter int unsigned MW = 23
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // operand handshake
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [MW-1:0]   i_mant_a,
    input  logic [MW-1:0]   i_mant_b,
    // product handshake
    output logic            o_valid,
    input  logic            i_ready,
    output logic [2*MW-1:0] o_product,
    // external adder
    output logic [2*MW-1:0] o_add_one,
    output logic [2*MW-1:0] o_add_two,
    output logic            o_add_carry,
    input  logic [2*MW-1:0] i_add_sum,
    input  logic            i_add_carry,
    // status
    output logic            o_err
);

    localparam int unsigned PW = 2 * MW;
    localparam int unsigned CW = $clog2(MW + 1);
    localparam logic [CW-1:0] LastCnt = CW'(MW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        r_state, w_state_nxt;
    logic [PW-1:0] r_p, w_p_nxt;
    logic [PW-1:0] r_a, w_a_nxt;
    logic [MW-1:0] r_b, w_b_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_err, w_err_nxt;

    logic [MW-1:0] w_b_shift;
    logic          w_last;

    assign w_b_shift = r_b >> 1;

    // Decide whether the current RUN iteration is the final one.
    always_comb begin
`ifdef MANT_MUL_EARLY_EXIT_EN
        // Once no multiplier bits remain, further additions would add zero.
        w_last = (w_b_shift == '0) || (r_cnt == LastCnt);
`else
        w_last = (r_cnt == LastCnt);
`endif
    end

    // Next-state and datapath update for the three-state sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_valid) begin
                    w_p_nxt     = '0;
                    w_a_nxt     = {{MW{1'b0}}, i_mant_a};
                    w_b_nxt     = i_mant_b;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                // A carry-out is impossible for in-range operands; flag it
                // but keep the truncated sum and carry on.
                w_p_nxt   = i_add_sum;
                w_a_nxt   = r_a << 1;
                w_b_nxt   = w_b_shift;
                w_cnt_nxt = r_cnt + CW'(1);
                w_err_nxt = i_add_carry;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                // Back to IDLE first; new operands are never taken on the
                // same edge as the product handshake.
                if (i_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, datapath and error-pulse registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_p     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        o_ready     = (r_state == StIdle);
        o_valid     = (r_state == StDone);
        o_product   = r_p;
        o_add_one   = '0;
        o_add_two   = '0;
        o_add_carry = 1'b0;
        o_err       = r_err;
        if (r_state == StRun) begin
            o_add_one = r_p;
            o_add_two = r_b[0] ? r_a : '0;
        end
    end

endmodule

// File: tb/tb_mant_mul_ctrl.sv
// tb_mant_mul_ctrl: directed self-checking bench for mant_mul_ctrl,
// including a behavioural model of the external ripple adder.
module tb_mant_mul_ctrl;

    localparam int unsigned MW = 23;
    localparam int unsigned PW = 2 * MW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [MW-1:0] i_mant_a;
    logic [MW-1:0] i_mant_b;
    logic          o_valid;
    logic          i_ready;
    logic [PW-1:0] o_product;
    logic [PW-1:0] o_add_one;
    logic [PW-1:0] o_add_two;
    logic          o_add_carry;
    logic [PW-1:0] i_add_sum;
    logic          i_add_carry;
    logic          o_err;

    logic          force_carry;
    logic [PW:0]   sum_full;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    mant_mul_ctrl #(.MW(MW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mant_a   (i_mant_a),
        .i_mant_b   (i_mant_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_product  (o_product),
        .o_add_one  (o_add_one),
        .o_add_two  (o_add_two),
        .o_add_carry(o_add_carry),
        .i_add_sum  (i_add_sum),
        .i_add_carry(i_add_carry),
        .o_err      (o_err)
    );

    // External adder model; force_carry injects a spurious carry-out.
    assign sum_full    = {1'b0, o_add_one} + {1'b0, o_add_two} + {{PW{1'b0}}, o_add_carry};
    assign i_add_sum   = sum_full[PW-1:0];
    assign i_add_carry = sum_full[PW] | force_carry;

    always #5 i_clk = ~i_clk;

    // Count error pulses, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (o_err) err_seen = err_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [MW-1:0] b);
`ifdef MANT_MUL_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < int'(MW); i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
`else
        return int'(MW);
`endif
    endfunction

    // Present operands and take the accepting edge; operands then scrambled.
    task automatic accept(input logic [MW-1:0] a, input logic [MW-1:0] b);
        i_mant_a = a;
        i_mant_b = b;
        i_valid  = 1'b1;
        check("ready_before_accept", 64'(o_ready), 64'd1);
        tick();
        i_valid  = 1'b0;
        i_mant_a = MW'($urandom);
        i_mant_b = MW'($urandom);
    endtask

    // Count edges until o_valid, starting from edges already elapsed.
    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!o_valid && n < 200) begin
            tick();
            n = n + 1;
        end
    endtask

    // Full transaction with i_ready held high.
    task automatic run_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic [PW-1:0] exp_p, input int exp_lat);
        int n;
        i_ready = 1'b1;
        accept(a, b);
        wait_valid(0, n);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_product"}, 64'(o_product), 64'(exp_p));
        tick();
        check({tag, "_valid_drop"}, 64'(o_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        int n;
        logic [PW-1:0] held;
        logic          stable;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_mant_a    = '0;
        i_mant_b    = '0;
        force_carry = 1'b0;

        // Reset then idle
        tick();
        tick();
        i_rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_product", 64'(o_product), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_add_one", 64'(o_add_one), 64'd0);
        check("rst_add_two", 64'(o_add_two), 64'd0);
        check("rst_add_carry", 64'(o_add_carry), 64'd0);

        // Adder operand sequencing: a=3, b=5 (b bits 1,0,1)
        i_ready = 1'b1;
        accept(MW'(3), MW'(5));
        check("run0_ready", 64'(o_ready), 64'd0);
        check("run0_add_one", 64'(o_add_one), 64'd0);
        check("run0_add_two", 64'(o_add_two), 64'd3);
        tick();
        check("run1_add_one", 64'(o_add_one), 64'd3);
        check("run1_add_two", 64'(o_add_two), 64'd0);
        tick();
        check("run2_add_two", 64'(o_add_two), 64'd12);
        wait_valid(2, n);
        check("basic_latency", 64'(n), 64'(exp_latency(MW'(5))));
        check("basic_product", 64'(o_product), 64'd15);
        check("done_add_one", 64'(o_add_one), 64'd0);
        check("done_add_two", 64'(o_add_two), 64'd0);
        tick();
        check("basic_ready_back", 64'(o_ready), 64'd1);

        // Max operands, no error pulse
        err_seen = 0;
        run_op("max", MW'(23'h7FFFFF), MW'(23'h7FFFFF), PW'(46'h3FFFFF000001), exp_latency(MW'(23'h7FFFFF)));
        check("max_no_err", 64'(err_seen), 64'd0);

        // Back-to-back throughput: accept again on the cycle o_ready returns
        run_op("b2b", MW'(23'h000ABC), MW'(23'h000100), PW'(46'h0ABC00), exp_latency(MW'(23'h000100)));

        // Backpressure
        i_ready = 1'b0;
        accept(MW'(23'h001234), MW'(23'h000056));
        wait_valid(0, n);
        check("bp_latency", 64'(n), 64'(exp_latency(MW'(23'h000056))));
        check("bp_product", 64'(o_product), 64'h61D78);
        held   = o_product;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid  = ~i_valid;
            i_mant_a = MW'($urandom);
            i_mant_b = MW'($urandom);
            tick();
            if (o_product !== held || o_valid !== 1'b1 || o_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_hold_stable", 64'(stable), 64'd1);
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        check("bp_valid_drop", 64'(o_valid), 64'd0);
        check("bp_ready_back", 64'(o_ready), 64'd1);
        i_valid = 1'b0;
        tick();
        check("bp_no_accept_in_done", 64'(o_ready), 64'd1);

        // Reset mid-operation at RUN cycle 12
        accept(MW'(23'h55), MW'(23'h7FFFFF));
        for (int i = 0; i < 12; i++) tick();
        check("mid_running", 64'(o_ready), 64'd0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mid_rst_ready", 64'(o_ready), 64'd1);
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        check("mid_rst_product", 64'(o_product), 64'd0);
        run_op("after_rst", MW'(2), MW'(2), PW'(4), exp_latency(MW'(2)));

        // Reset while holding a product in DONE
        i_ready = 1'b0;
        accept(MW'(7), MW'(1));
        wait_valid(0, n);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("done_rst_valid", 64'(o_valid), 64'd0);
        check("done_rst_ready", 64'(o_ready), 64'd1);

        // Injected carry-out: one-cycle error pulse, computation continues
        err_seen = 0;
        i_ready  = 1'b1;
        accept(MW'(1), MW'(23'h400001));
        force_carry = 1'b1;
        tick();
        force_carry = 1'b0;
        check("err_pulse", 64'(o_err), 64'd1);
        tick();
        check("err_single", 64'(o_err), 64'd0);
        wait_valid(2, n);
        check("err_latency", 64'(n), 64'(MW));
        check("err_product", 64'(o_product), 64'h400001);
        check("err_count", 64'(err_seen), 64'd1);
        tick();

        // Early-exit boundary cases (full latency without the macro)
        run_op("ee_b1", MW'(23'h1ABCDE), MW'(1), PW'(46'h1ABCDE), exp_latency(MW'(1)));
        run_op("ee_b0", MW'(23'h1ABCDE), MW'(0), PW'(0), exp_latency(MW'(0)));
        run_op("ee_bmsb", MW'(3), MW'(23'h400000), PW'(46'hC00000), int'(MW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mant_mul_ctrl.md
# mant_mul_ctrl

Sequential shift-and-add mantissa multiplier controller for the floating-point multiply path. It accepts two MW-bit mantissas over a valid/ready handshake and drives the shared 2·MW-bit ripple adder (46 bits at default) for one partial-product addition per cycle. It returns the 2·MW-bit product over a second valid/ready handshake. The adder sits outside this block; the block sequences the adder's operands and owns the accumulator and the iteration counter.

## Interface
- MW, 23, operand width; adder and product width is 2·MW
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  operand pair valid
- o_ready  out  1  block can accept operands (high only in IDLE)
- i_mant_a  in  MW  multiplicand
- i_mant_b  in  MW  multiplier
- o_valid  out  1  product valid
- i_ready  in  1  consumer accepts product
- o_product  out  2·MW  product a·b
- o_add_one  out  2·MW  adder operand one (accumulator)
- o_add_two  out  2·MW  adder operand two (gated shifted multiplicand)
- o_add_carry  out  1  adder carry-in, always 0
- i_add_sum  in  2·MW  adder sum
- i_add_carry  in  1  adder carry-out
- o_err  out  1  one-cycle pulse: adder carry-out seen during RUN

## Operation
- The clock is i_clk. Reset i_rst is synchronous and active-high.
- Registers:
  - accumulator P (2·MW bits)
  - shifted multiplicand A (2·MW bits)
  - multiplier shift register B (MW bits)
  - counter cnt (ceil(log2(MW+1)) bits)
- States and transitions:
  - IDLE: o_ready=1. On i_valid, load P=0, A=zero-extended i_mant_a, B=i_mant_b, cnt=0, then go to RUN.
  - RUN: drive o_add_one=P and o_add_two = B[0] ? A : 0. Register P<=i_add_sum, A<=A<<1, B<=B>>1, cnt<=cnt+1. When cnt==MW-1, go to DONE.
  - DONE: o_valid=1 and o_product=P, both held stable until i_valid-independent acceptance on i_ready. On i_ready, go to IDLE.
- Operand capture and port behaviour:
  - Operands are sampled only on the accepting edge. Later changes on i_mant_a or i_mant_b are ignored.
  - i_valid while not in IDLE is ignored; o_ready stays 0.
  - In DONE, no new operands are accepted in the same cycle as product acceptance. o_ready rises the cycle after the product handshake.
  - Outside RUN, o_add_one and o_add_two are 0.
- Arithmetic: the product always fits in 2·MW bits, so i_add_carry must be 0. If i_add_carry=1 in RUN, o_err pulses for one cycle. The sum is still taken and computation continues.
- Reset: i_rst in any state, including mid-RUN or DONE with i_ready=0, returns the block to IDLE and discards the operation.
- Reset values:
  - o_ready=1
  - o_valid=0
  - o_product=0
  - o_add_one=0
  - o_add_two=0
  - o_add_carry=0
  - o_err=0
  - P=0, A=0, B=0, cnt=0

## Timing
- Accepting edge: the rising edge with state=IDLE and i_valid=1.
- Latency: o_valid rises exactly MW edges after the accepting edge (23 cycles at default).
- Throughput: one product per MW+2 cycles with i_ready held high.
- The adder is combinational. i_add_sum must settle within one i_clk period of o_add_one/o_add_two; the block adds no pipeline stage.
- o_product and o_valid are registered. o_ready, o_add_one, o_add_two and o_err are decoded from registered state and have no combinational path from i_valid or i_ready.

## Configuration
- MANT_MUL_EARLY_EXIT_EN
  - Defined: in RUN, if the next value of B is zero, go to DONE after the current iteration regardless of cnt. Latency becomes max(1, position of the highest set bit of i_mant_b + 1) edges. i_mant_b=0 gives 1 edge.
  - Undefined: fixed MW-iteration latency for every operand pair.
  - The product value is identical in both builds.

## Test plan
- Reset then idle: assert i_rst for 2 cycles → o_ready=1, o_valid=0, o_product=0, o_err=0.
- Basic product: a=3, b=5 with i_ready=1 → o_valid exactly 23 edges after accept, o_product=15. Next cycle o_ready=1.
- Max operands: a=b=0x7FFFFF → o_product=0x3FFFFF000001, o_err never pulses.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid rises, toggle i_valid and change operands → o_product stable, no new accept, then product accepted on i_ready.
- Reset mid-operation: assert i_rst at RUN cycle 12 → next cycle IDLE, o_valid=0, the new operation a=2, b=2 yields 4.
- Early exit (macro defined): b=1 → o_valid 1 edge after accept, product=a. b=0x400000 → o_valid after 23 edges. Without the macro both cases take 23 edges.
